// File: rtl/brew_sequencer_if.sv
// Control and status bundle between the brew sequencer and the front panel / display logic.
// Handshake: start is taken only on a cycle where ready=1, pod_present=1 and water_ok=1; a start pulse
// at any other time is dropped, never queued. cancel is a one-cycle request honoured on the next edge.
interface brew_sequencer_if;
    logic       start;
    logic       cancel;
    logic [1:0] cup_size;
    logic       pod_present;
    logic       water_ok;
    logic       heater_on;
    logic       pump_on;
    logic       ready;
    logic       done;
    logic       fault;
    logic [2:0] phase;
    logic [7:0] secs_remaining;

    modport master (
        output start, cancel, cup_size, pod_present, water_ok,
        input  heater_on, pump_on, ready, done, fault, phase, secs_remaining
    );

    modport slave (
        input  start, cancel, cup_size, pod_present, water_ok,
        output heater_on, pump_on, ready, done, fault, phase, secs_remaining
    );
endinterface

// File: rtl/brew_sequencer.sv
// Brew-cycle controller: heat -> brew -> done sequencing on a 1 s enable derived from clk_100MHz.
// phase doubles as the visible state register for display and debug.
module brew_sequencer #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int HEAT_SECS  = 30,
    parameter int SMALL_SECS = 20,
    parameter int MED_SECS   = 30,
    parameter int LARGE_SECS = 40,
    parameter int DONE_SECS  = 5
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    brew_sequencer_if.slave   bus
);

    localparam int CNT_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HEAT  = 3'd1,
        S_BREW  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [7:0]       secs;
    logic [7:0]       next_secs;
    logic [CNT_W-1:0] tick_cnt;
    logic [1:0]       size_q;
    logic [7:0]       brew_len;
    logic             latch_size;
    logic             running;
    logic             tick;

    always_comb begin
        case (size_q)
            2'b00:   brew_len = 8'(SMALL_SECS);
            2'b01:   brew_len = 8'(MED_SECS);
            default: brew_len = 8'(LARGE_SECS);
        endcase
    end

    assign running = (state == S_HEAT) || (state == S_BREW) || (state == S_DONE);
    assign tick    = running && (tick_cnt == CNT_W'(TICK_DIV - 1));

    // Priority: cancel > water loss > tick > start.
    always_comb begin
        next_state = state;
        next_secs  = secs;
        latch_size = 1'b0;
        if (bus.cancel && state != S_IDLE) begin
            next_state = S_IDLE;
            next_secs  = 8'd0;
        end else if (!bus.water_ok && (state == S_HEAT || state == S_BREW)) begin
            next_state = S_FAULT;
            next_secs  = 8'd0;
        end else if (tick) begin
            if (secs == 8'd1) begin
                case (state)
                    S_HEAT: begin
                        next_state = S_BREW;
                        next_secs  = brew_len;
                    end
                    S_BREW: begin
                        next_state = S_DONE;
                        next_secs  = 8'(DONE_SECS);
                    end
                    default: begin
                        next_state = S_IDLE;
                        next_secs  = 8'd0;
                    end
                endcase
            end else begin
                next_secs = secs - 8'd1;
            end
        end else if (state == S_IDLE && bus.start && bus.pod_present && bus.water_ok) begin
            next_state = S_HEAT;
            next_secs  = 8'(HEAT_SECS);
            latch_size = 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            secs          <= 8'd0;
            tick_cnt      <= '0;
            size_q        <= 2'b00;
            bus.heater_on <= 1'b0;
            bus.pump_on   <= 1'b0;
            bus.ready     <= 1'b1;
            bus.done      <= 1'b0;
            bus.fault     <= 1'b0;
        end else begin
            state <= next_state;
            secs  <= next_secs;
            if (latch_size) begin
                size_q <= bus.cup_size;
            end
            // Restarting the count on every phase change keeps each phase a whole number of seconds.
            if (next_state != state || !running || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
            bus.heater_on <= (next_state == S_HEAT) || (next_state == S_BREW);
            bus.pump_on   <= (next_state == S_BREW);
            bus.ready     <= (next_state == S_IDLE);
            bus.done      <= (next_state == S_DONE);
            bus.fault     <= (next_state == S_FAULT);
        end
    end

    assign bus.phase          = state;
    assign bus.secs_remaining = secs;

endmodule

// File: tb/tb_brew_sequencer.sv
// Self-checking bench for brew_sequencer: per-edge timeline model computed from phase durations,
// randomized cup sizes, spurious starts, cancels and water loss.
module tb_brew_sequencer;
    localparam int TD     = 10;
    localparam int HEAT_S = 3;
    localparam int SMALL  = 2;
    localparam int MED    = 4;
    localparam int LARGE  = 6;
    localparam int DONE_S = 2;
    localparam int HEAT_C = HEAT_S * TD;
    localparam int DONE_C = DONE_S * TD;

    typedef struct packed {
        logic [2:0] phase;
        logic [7:0] secs;
        logic       heater;
        logic       pump;
        logic       done;
        logic       fault;
        logic       ready;
    } obs_t;

    localparam obs_t IDLE_OBS  = '{phase: 3'd0, secs: 8'd0, heater: 1'b0, pump: 1'b0, done: 1'b0, fault: 1'b0, ready: 1'b1};
    localparam obs_t FAULT_OBS = '{phase: 3'd4, secs: 8'd0, heater: 1'b0, pump: 1'b0, done: 1'b0, fault: 1'b1, ready: 1'b0};

    logic clk_100MHz = 1'b0;
    logic reset      = 1'b0;
    int   n_total    = 0;
    int   n_pass     = 0;
    logic [15:0] exp_q[$];

    brew_sequencer_if bif ();

    brew_sequencer #(
        .TICK_DIV(TD), .HEAT_SECS(HEAT_S), .SMALL_SECS(SMALL),
        .MED_SECS(MED), .LARGE_SECS(LARGE), .DONE_SECS(DONE_S)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset(reset),
        .bus(bif.slave)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic obs_t sample();
        return '{phase: bif.phase, secs: bif.secs_remaining, heater: bif.heater_on, pump: bif.pump_on,
                 done: bif.done, fault: bif.fault, ready: bif.ready};
    endfunction

    function automatic string show(obs_t o);
        return $sformatf("ph=%0d s=%0d h=%0b p=%0b d=%0b f=%0b r=%0b",
                         o.phase, o.secs, o.heater, o.pump, o.done, o.fault, o.ready);
    endfunction

    function automatic int brew_secs(logic [1:0] size);
        case (size)
            2'b00:   return SMALL;
            2'b01:   return MED;
            default: return LARGE;
        endcase
    endfunction

    // Expected outputs just after the k-th edge counted from the accepted start edge (k=0).
    function automatic obs_t model(logic [1:0] size, int k);
        obs_t o;
        int   b_c;
        b_c = brew_secs(size) * TD;
        o   = IDLE_OBS;
        if (k < HEAT_C) begin
            o = '{phase: 3'd1, secs: 8'(HEAT_S - k / TD), heater: 1'b1, pump: 1'b0, done: 1'b0, fault: 1'b0, ready: 1'b0};
        end else if (k < HEAT_C + b_c) begin
            o = '{phase: 3'd2, secs: 8'(brew_secs(size) - (k - HEAT_C) / TD), heater: 1'b1, pump: 1'b1,
                  done: 1'b0, fault: 1'b0, ready: 1'b0};
        end else if (k < HEAT_C + b_c + DONE_C) begin
            o = '{phase: 3'd3, secs: 8'(DONE_S - (k - HEAT_C - b_c) / TD), heater: 1'b0, pump: 1'b0,
                  done: 1'b1, fault: 1'b0, ready: 1'b0};
        end
        return o;
    endfunction

    // Runs one cycle from IDLE; cancel_at / fault_at = 0 means not injected.
    task automatic run_brew(input logic [1:0] size, input int cancel_at, input int fault_at, input bit noise,
                            input string name);
        int   total;
        int   last;
        obs_t e;
        obs_t got;
        total = HEAT_C + brew_secs(size) * TD + DONE_C;
        last  = total;
        if (cancel_at > 0) last = cancel_at;
        if (fault_at > 0 && (cancel_at == 0 || fault_at < cancel_at)) last = fault_at;
        exp_q.delete();
        for (int k = 0; k <= last; k++) begin
            if (k == last && last != total) e = (cancel_at == last) ? IDLE_OBS : FAULT_OBS;
            else e = model(size, k);
            exp_q.push_back(e);
        end
        for (int k = 0; k <= last; k++) begin
            @(negedge clk_100MHz);
            if (k == 0) begin
                bif.start       = 1'b1;
                bif.cup_size    = size;
                bif.pod_present = 1'b1;
                bif.water_ok    = 1'b1;
                bif.cancel      = 1'b0;
            end else begin
                bif.start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bif.cup_size = noise ? 2'($urandom_range(0, 3)) : bif.cup_size;
                bif.cancel   = (k == cancel_at);
                // Water is not monitored in DONE, so noise may drop it there.
                if (k == fault_at) bif.water_ok = 1'b0;
                else if (noise && model(size, k - 1).phase == 3'd3) bif.water_ok = 1'($urandom_range(0, 1));
                else bif.water_ok = 1'b1;
            end
            @(posedge clk_100MHz);
            #1;
            got = sample();
            e   = obs_t'(exp_q.pop_front());
            n_total++;
            if (got !== e) $display("FAIL %s k=%0d got %s exp %s", name, k, show(got), show(e));
            else n_pass++;
        end
        @(negedge clk_100MHz);
        bif.start    = 1'b0;
        bif.cancel   = 1'b0;
        bif.water_ok = 1'b1;
    endtask

    task automatic recover_from_fault(input string name);
        obs_t got;
        repeat (12) @(posedge clk_100MHz);
        #1;
        got = sample();
        n_total++;
        if (got !== FAULT_OBS) $display("FAIL %s_hold got %s exp %s", name, show(got), show(FAULT_OBS));
        else n_pass++;
        @(negedge clk_100MHz);
        bif.cancel = 1'b1;
        @(posedge clk_100MHz);
        #1;
        got = sample();
        n_total++;
        if (got !== IDLE_OBS) $display("FAIL %s_cancel got %s exp %s", name, show(got), show(IDLE_OBS));
        else n_pass++;
        @(negedge clk_100MHz);
        bif.cancel = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        repeat (3) @(negedge clk_100MHz);
        got = sample();
        n_total++;
        if (got !== IDLE_OBS) $display("FAIL reset_init got %s exp %s", show(got), show(IDLE_OBS));
        else n_pass++;
        reset = 1'b1;
        @(negedge clk_100MHz);
        bif.start = 1'b1; bif.cup_size = 2'b00; bif.pod_present = 1'b1; bif.water_ok = 1'b1;
        @(negedge clk_100MHz);
        bif.start = 1'b0;
        repeat (35) @(posedge clk_100MHz);
        #1;
        n_total++;
        if (bif.phase !== 3'd2) $display("FAIL reset_pre_brew got ph=%0d exp ph=2", bif.phase);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        got = sample();
        n_total++;
        if (got !== IDLE_OBS) $display("FAIL reset_async got %s exp %s", show(got), show(IDLE_OBS));
        else n_pass++;
        @(negedge clk_100MHz);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_100MHz);
            bif.start       = 1'b1;
            bif.pod_present = (i == 1);
            bif.water_ok    = (i == 0);
            @(negedge clk_100MHz);
            bif.start = 1'b0;
            repeat (3) @(posedge clk_100MHz);
            #1;
            got = sample();
            n_total++;
            if (got !== IDLE_OBS) $display("FAIL start_ignored_%0d got %s exp %s", i, show(got), show(IDLE_OBS));
            else n_pass++;
        end
        @(negedge clk_100MHz);
        bif.pod_present = 1'b1;
        bif.water_ok    = 1'b1;
        bif.cancel      = 1'b1;
        @(posedge clk_100MHz);
        #1;
        got = sample();
        n_total++;
        if (got !== IDLE_OBS) $display("FAIL cancel_in_idle got %s exp %s", show(got), show(IDLE_OBS));
        else n_pass++;
        @(negedge clk_100MHz);
        bif.cancel = 1'b0;
    endtask

    task automatic test_full_small();
        run_brew(2'b00, 0, 0, 1'b0, "full_small");
    endtask

    task automatic test_size_latch();
        run_brew(2'b11, 0, 0, 1'b1, "size_latch");
    endtask

    task automatic test_water_fault();
        // MED brew shows secs=3 during its second second; the tick cycle precedes edge HEAT_C+2*TD.
        run_brew(2'b01, 0, HEAT_C + 2 * TD, 1'b0, "water_fault");
        recover_from_fault("water_fault");
    endtask

    task automatic test_cancel_priority();
        run_brew(2'b01, 5, 5, 1'b0, "cancel_prio");
        run_brew(2'b01, 0, 0, 1'b0, "restart_after_cancel");
    endtask

    task automatic test_ignored_start();
        run_brew(2'b00, 0, 0, 1'b1, "ignored_start");
    endtask

    task automatic test_random();
        logic [1:0] size;
        int         mode;
        int         total;
        for (int i = 0; i < 10; i++) begin
            size  = 2'($urandom_range(0, 3));
            mode  = $urandom_range(0, 2);
            total = HEAT_C + brew_secs(size) * TD + DONE_C;
            if (mode == 0) begin
                run_brew(size, 0, 0, 1'b1, "rand_full");
            end else if (mode == 1) begin
                run_brew(size, $urandom_range(1, total), 0, 1'b1, "rand_cancel");
            end else begin
                run_brew(size, 0, $urandom_range(1, HEAT_C + brew_secs(size) * TD), 1'b1, "rand_fault");
                recover_from_fault("rand_fault");
            end
        end
    endtask

    initial begin
        bif.start       = 1'b0;
        bif.cancel      = 1'b0;
        bif.cup_size    = 2'b00;
        bif.pod_present = 1'b0;
        bif.water_ok    = 1'b1;
        test_reset();
        test_full_small();
        test_size_latch();
        test_water_fault();
        test_cancel_priority();
        test_ignored_start();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
